// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq_if
//  Description : Handshake bundle for the sequential binary-to-BCD converter.
//                Input side: in_valid/in_ready/bin_in.
//                Output side: out_valid/out_ready/bcd_out/overflow.
//                When SEG7_EN is defined it also carries seg_out.
//  Revision    : 1.0  initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
`ifdef SEG7_EN
    logic [7*DIGITS-1:0]   seg_out;
`endif

    // Producer/consumer side (drives the inputs, takes the results)
    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, overflow
`ifdef SEG7_EN
        , input seg_out
`endif
    );

    // Converter side
    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, overflow
`ifdef SEG7_EN
        , output seg_out
`endif
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter. One binary
//                bit is shifted into the BCD chain per cycle after each
//                nibble >= 5 is corrected by +3. Results are offered on a
//                valid/ready handshake. Optional macro SEG7_EN adds a
//                registered gfedcba seven-segment decode of every digit.
//  Revision    : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bin_to_bcd_seq_if.slave      bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic               w_last_shift;

    // Add-3 correction applied independently to each nibble
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign w_bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                                     (bcd_q[4*i +: 4] + 4'd3) : bcd_q[4*i +: 4];
    end

    // Corrected chain shifted left with the next binary bit entering at bit 0
    assign w_bcd_shift  = {w_bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign w_last_shift = (state_q == S_SHIFT) && (cnt_q == CNT_W'(1));

    // Next-state and datapath update for the accept / shift / hand-off flow
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    bin_d   = bus.bin_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = w_bcd_shift;
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                // The bit pushed out of the top digit means the value overflowed
                ovf_d = ovf_q | w_bcd_adj[BCD_W-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (w_last_shift) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = ovf_q;

`ifdef SEG7_EN
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [7*DIGITS-1:0] w_seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // Decode the final chain so segments change on the same edge as bcd_out
    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        assign w_seg_next[7*i +: 7] = seg_decode(w_bcd_shift[4*i +: 4]);
    end

    // Segment register loads only on the last shift
    always_comb begin
        seg_d = seg_q;
        if (w_last_shift) begin
            seg_d = w_seg_next;
        end
    end

    // Segment pattern register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.seg_out = seg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. A 3-digit converter
//                and a 2-digit converter are driven with directed and random
//                values; results are compared with decimal arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ifa ();
    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ifb ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: digit i is (v / 10^i) mod 10
    function automatic logic [31:0] bcd_model(input int v, input int nd);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction on the 3-digit converter; hold = cycles out_ready stays low in DONE
    task automatic run_a(input logic [7:0] v, input int hold, input string tag);
        int          lat;
        logic [31:0] exp_bcd;
        logic [31:0] exp_seg;
        exp_bcd = bcd_model(int'(v), 3);
        exp_seg = '0;
        for (int i = 0; i < 3; i++) begin
            exp_seg[7*i +: 7] = seg_of(int'(exp_bcd[4*i +: 4]));
        end
        ifa.out_ready = (hold == 0);
        lat = 0;
        while (!ifa.in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".idle_ready"}, 32'(ifa.in_ready), 32'd1);
        ifa.in_valid = 1'b1;
        ifa.bin_in   = v;
        @(negedge clk);
        // Keep offering a different value while busy; it must be ignored
        ifa.bin_in = ~v;
        chk({tag, ".busy_ready"}, 32'(ifa.in_ready), 32'd0);
        lat = 0;
        while (!ifa.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        chk({tag, ".bcd"}, 32'(ifa.bcd_out), exp_bcd);
        chk({tag, ".ovf"}, 32'(ifa.overflow), 32'd0);
`ifdef SEG7_EN
        chk({tag, ".seg"}, 32'(ifa.seg_out), exp_seg);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(ifa.out_valid), 32'd1);
            chk({tag, ".hold_bcd"}, 32'(ifa.bcd_out), exp_bcd);
            chk({tag, ".hold_ready"}, 32'(ifa.in_ready), 32'd0);
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".post_valid"}, 32'(ifa.out_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(ifa.in_ready), 32'd1);
        chk({tag, ".post_bcd"}, 32'(ifa.bcd_out), exp_bcd);
        ifa.out_ready = 1'b0;
    endtask

    // Transaction on the 2-digit converter, where values above 99 overflow
    task automatic run_b(input logic [7:0] v, input string tag);
        int lat;
        ifb.out_ready = 1'b0;
        lat = 0;
        while (!ifb.in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        ifb.in_valid = 1'b1;
        ifb.bin_in   = v;
        @(negedge clk);
        ifb.in_valid = 1'b0;
        lat = 0;
        while (!ifb.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        chk({tag, ".bcd"}, 32'(ifb.bcd_out), bcd_model(int'(v), 2));
        chk({tag, ".ovf"}, 32'(ifb.overflow), 32'(int'(v) > 99));
        ifb.out_ready = 1'b1;
        @(negedge clk);
        ifb.out_ready = 1'b0;
        chk({tag, ".post_ready"}, 32'(ifb.in_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.bin_in    = '0;
        ifa.out_ready = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.bin_in    = '0;
        ifb.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst.out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst.bcd", 32'(ifa.bcd_out), 32'd0);
        chk("rst.ovf", 32'(ifa.overflow), 32'd0);
`ifdef SEG7_EN
        chk("rst.seg", 32'(ifa.seg_out), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_a(8'd255, 0, "v255");
        run_a(8'd0,   0, "v0");
        run_a(8'd99,  1, "v99");
        run_a(8'd137, 5, "v137");
        run_a(8'd5,   0, "v5");

        // Asynchronous reset in the middle of a conversion
        ifa.in_valid = 1'b1;
        ifa.bin_in   = 8'd200;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", 32'(ifa.in_ready), 32'd1);
        chk("midrst.out_valid", 32'(ifa.out_valid), 32'd0);
        chk("midrst.bcd", 32'(ifa.bcd_out), 32'd0);
        chk("midrst.ovf", 32'(ifa.overflow), 32'd0);
`ifdef SEG7_EN
        chk("midrst.seg", 32'(ifa.seg_out), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_a(8'd42, 0, "v42");

        // Narrow converter: overflow and modulo behaviour
        run_b(8'd200, "b200");
        run_b(8'd99,  "b99");
        run_b(8'd100, "b100");
        run_b(8'd0,   "b0");

        // Random values against the decimal model
        for (int n = 0; n < 20; n++) begin
            run_a(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "rnd_a");
        end
        for (int n = 0; n < 10; n++) begin
            run_b(8'($urandom_range(0, 255)), "rnd_b");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
